// File: rtl/lsu.sv
// RV32I load/store unit: word-wide memory port, sub-word stores done as read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_write_data_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_read_data_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t      state_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] buf_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        misalign;
  logic        req_err;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] load_d;
  logic [31:0] merge_d;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                    ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_funct3_i == 3'b011) || (req_funct3_i[2] && req_funct3_i[1]) ||
                   (req_we_i && req_funct3_i[2]) || misalign;

  assign byte_sh = mem_read_data_i >> {addr_q[1:0], 3'b000};
  assign half_sh = mem_read_data_i >> {addr_q[1], 4'b0000};

  always_comb begin
    load_d = mem_read_data_i;
    case (funct3_q[1:0])
      2'b00:   load_d = {{24{byte_sh[7]  & ~funct3_q[2]}}, byte_sh[7:0]};
      2'b01:   load_d = {{16{half_sh[15] & ~funct3_q[2]}}, half_sh[15:0]};
      default: load_d = mem_read_data_i;
    endcase
  end

  // Only the low byte/halfword of the latched store data lands in the addressed lane.
  always_comb begin
    merge_d = mem_read_data_i;
    if (funct3_q[1:0] == 2'b00)
      merge_d[{addr_q[1:0], 3'b000} +: 8] = buf_q[7:0];
    else
      merge_d[{addr_q[1], 4'b0000} +: 16] = buf_q[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      buf_q    <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            buf_q    <= req_wdata_i;
            rdata_q  <= 32'h0;
            err_q    <= req_err;
            if (req_err)
              state_q <= S_RESP;
            else if (!req_we_i)
              state_q <= S_LOAD;
            else if (req_funct3_i[1:0] == 2'b10)
              state_q <= S_WR;
            else
              state_q <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          rdata_q <= load_d;
          state_q <= S_RESP;
        end
        S_RMW_RD: begin
          buf_q   <= merge_d;
          state_q <= S_WR;
        end
        S_WR:    state_q <= S_RESP;
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign resp_valid_o     = (state_q == S_RESP);
  assign resp_rdata_o     = rdata_q;
  assign resp_err_o       = err_q;
  assign mem_addr_o       = {addr_q[31:2], 2'b00};
  assign mem_write_data_o = (state_q == S_WR) ? buf_q : 32'h0;
  // Gated by reset so an interrupted store never reaches memory.
  assign mem_read_o       = ((state_q == S_LOAD) || (state_q == S_RMW_RD)) && !rst_i;
  assign mem_write_o      = (state_q == S_WR) && !rst_i;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a small word-addressed memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic        tb_init;
  logic [31:0] mem [0:63];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_funct3_i     (req_funct3),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_rdata_o     (resp_rdata),
    .resp_err_o       (resp_err),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_write_data),
    .mem_write_o      (mem_write),
    .mem_read_o       (mem_read),
    .mem_read_data_i  (mem_read_data)
  );

  assign mem_read_data = mem_read ? mem[mem_addr[7:2]] : 32'hA5A5A5A5;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_write_data;
    end
  end

  // Drives one request, scrambles the request inputs after acceptance, and
  // records the response cycle (1 = cycle after acceptance) plus memory traffic.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int rc, output logic [31:0] rd,
                        output logic er, output int nrd, output int nwr,
                        output logic [31:0] wd, output logic [31:0] ma);
    rc = 0; rd = 32'hX; er = 1'bX; nrd = 0; nwr = 0; wd = 32'h0; ma = 32'hX;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b010; req_addr = 32'h3F; req_wdata = 32'h5A5A5A5A;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_read) begin nrd++; ma = mem_addr; end
      if (mem_write) begin nwr++; wd = mem_write_data; ma = mem_addr; end
      if (resp_valid) begin
        rc = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", resp_valid); end
    vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", resp_err); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
    vectors++; if (mem_write_data !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h exp 0", mem_write_data); end
    vectors++; if ({mem_read, mem_write} !== 2'b00) begin miscompares++; $display("FAIL rst_rdwr got %b exp 00", {mem_read, mem_write}); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3   [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100, 3'b001};
    logic [31:0] ad   [8] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h10, 32'h11, 32'h10};
    logic [31:0] expv [8] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h00008899,
                              32'h8899AABB, 32'hFFFFFFBB, 32'h000000AA, 32'hFFFFAABB};
    int rc, nrd, nwr; logic [31:0] rd, wd, ma; logic er;
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, f3[i], ad[i], 32'h0, rc, rd, er, nrd, nwr, wd, ma);
      vectors++; if (rd !== expv[i]) begin miscompares++; $display("FAIL load%0d_data got %h exp %h", i, rd, expv[i]); end
      vectors++; if (rc !== 2 || er !== 1'b0) begin miscompares++; $display("FAIL load%0d_timing got cyc %0d err %b exp cyc 2 err 0", i, rc, er); end
      vectors++; if (nrd !== 1 || nwr !== 0 || ma !== 32'h10) begin miscompares++; $display("FAIL load%0d_mem got rd %0d wr %0d addr %h exp 1 0 10", i, nrd, nwr, ma); end
    end
  endtask

  task automatic test_subword_store;
    int rc, nrd, nwr; logic [31:0] rd, wd, ma; logic er;
    run_op(1'b1, 3'b000, 32'h11, 32'h123456CC, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (wd !== 32'h8899CCBB) begin miscompares++; $display("FAIL sb_merge got %h exp 8899ccbb", wd); end
    vectors++; if (rc !== 3 || nrd !== 1 || nwr !== 1) begin miscompares++; $display("FAIL sb_timing got cyc %0d rd %0d wr %0d exp 3 1 1", rc, nrd, nwr); end
    vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("FAIL sb_resp got %h err %b exp 0 0", rd, er); end
    run_op(1'b0, 3'b010, 32'h10, 32'h0, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (rd !== 32'h8899CCBB) begin miscompares++; $display("FAIL sb_readback got %h exp 8899ccbb", rd); end
    run_op(1'b1, 3'b001, 32'h12, 32'hFFFF1234, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (wd !== 32'h1234CCBB || rc !== 3 || ma !== 32'h10) begin miscompares++; $display("FAIL sh_merge got %h cyc %0d addr %h exp 1234ccbb 3 10", wd, rc, ma); end
    run_op(1'b0, 3'b010, 32'h10, 32'h0, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (rd !== 32'h1234CCBB) begin miscompares++; $display("FAIL sh_readback got %h exp 1234ccbb", rd); end
  endtask

  task automatic test_word_store;
    int rc, nrd, nwr; logic [31:0] rd, wd, ma; logic er;
    run_op(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (rc !== 2 || nrd !== 0 || nwr !== 1) begin miscompares++; $display("FAIL sw_timing got cyc %0d rd %0d wr %0d exp 2 0 1", rc, nrd, nwr); end
    vectors++; if (wd !== 32'hDEADBEEF || ma !== 32'h20) begin miscompares++; $display("FAIL sw_data got %h addr %h exp deadbeef 20", wd, ma); end
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL sw_resp_ready got %b exp 0", req_ready); end
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1 || mem_write_data !== 32'h0) begin miscompares++; $display("FAIL sw_idle got ready %b wdata %h exp 1 0", req_ready, mem_write_data); end
    run_op(1'b0, 3'b010, 32'h20, 32'h0, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_readback got %h exp deadbeef", rd); end
  endtask

  task automatic test_misalign;
    int rc, nrd, nwr; logic [31:0] rd, wd, ma; logic er;
    run_op(1'b0, 3'b010, 32'h22, 32'h0, rc, rd, er, nrd, nwr, wd, ma);
`ifdef LSU_MISALIGN_TRAP_EN
    vectors++; if (er !== 1'b1 || rd !== 32'h0 || rc !== 1 || nrd !== 0) begin miscompares++; $display("FAIL lw_mis got err %b data %h cyc %0d rd %0d exp 1 0 1 0", er, rd, rc, nrd); end
`else
    vectors++; if (er !== 1'b0 || rd !== 32'hDEADBEEF || rc !== 2 || ma !== 32'h20) begin miscompares++; $display("FAIL lw_mis got err %b data %h cyc %0d addr %h exp 0 deadbeef 2 20", er, rd, rc, ma); end
`endif
    run_op(1'b0, 3'b001, 32'h21, 32'h0, rc, rd, er, nrd, nwr, wd, ma);
`ifdef LSU_MISALIGN_TRAP_EN
    vectors++; if (er !== 1'b1 || rc !== 1 || nrd !== 0) begin miscompares++; $display("FAIL lh_mis got err %b cyc %0d rd %0d exp 1 1 0", er, rc, nrd); end
`else
    vectors++; if (er !== 1'b0 || rd !== 32'hFFFFBEEF || rc !== 2) begin miscompares++; $display("FAIL lh_mis got err %b data %h cyc %0d exp 0 ffffbeef 2", er, rd, rc); end
`endif
  endtask

  task automatic test_errors;
    int rc, nrd, nwr; logic [31:0] rd, wd, ma; logic er;
    run_op(1'b0, 3'b011, 32'h10, 32'h0, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (er !== 1'b1 || rd !== 32'h0 || rc !== 1 || nrd !== 0 || nwr !== 0) begin miscompares++; $display("FAIL f3_011 got err %b data %h cyc %0d rd %0d wr %0d exp 1 0 1 0 0", er, rd, rc, nrd, nwr); end
    run_op(1'b1, 3'b100, 32'h10, 32'hFF, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (er !== 1'b1 || rc !== 1 || nrd !== 0 || nwr !== 0) begin miscompares++; $display("FAIL store_bu got err %b cyc %0d rd %0d wr %0d exp 1 1 0 0", er, rc, nrd, nwr); end
    run_op(1'b0, 3'b111, 32'h10, 32'h0, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (er !== 1'b1 || rc !== 1) begin miscompares++; $display("FAIL f3_111 got err %b cyc %0d exp 1 1", er, rc); end
  endtask

  task automatic test_reset_mid_store;
    int rc, nrd, nwr; logic [31:0] rd, wd, ma; logic er;
    int seen_valid = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin miscompares++; $display("FAIL mid_rst_strobe got wr %b rd %b exp 0 0", mem_write, mem_read); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) seen_valid++;
      if (i == 0) begin
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b exp 1", req_ready); end
      end
    end
    vectors++; if (seen_valid !== 0) begin miscompares++; $display("FAIL mid_rst_resp got %0d pulses exp 0", seen_valid); end
    vectors++; if (mem[4] !== 32'h1234CCBB) begin miscompares++; $display("FAIL mid_rst_mem got %h exp 1234ccbb", mem[4]); end
    run_op(1'b0, 3'b010, 32'h10, 32'h0, rc, rd, er, nrd, nwr, wd, ma);
    vectors++; if (rd !== 32'h1234CCBB || rc !== 2) begin miscompares++; $display("FAIL mid_rst_readback got %h cyc %0d exp 1234ccbb 2", rd, rc); end
  endtask

  initial begin
    rst = 1'b1; tb_init = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    req_valid = 1'b0;
    #1;
    tb_init = 1'b0; rst = 1'b0;
    test_loads;
    test_subword_store;
    test_word_store;
    test_misalign;
    test_errors;
    test_reset_mid_store;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
